// File: rtl/red_pitaya_decim_avg_block_if.sv
// Sample/control inputs and decimated outputs of the boxcar averager.
interface red_pitaya_decim_avg_block_if #(
  parameter int SIGNALBITS = 14,
  parameter int LOGBITS    = 4,
  parameter int WINBITS    = 16
);
  logic [LOGBITS-1:0]           log2_n;
  logic                         enable;
  logic                         clear;
  logic signed [SIGNALBITS-1:0] signal_i;
  logic signed [SIGNALBITS-1:0] signal_o;
  logic signed [SIGNALBITS-1:0] min_o;
  logic signed [SIGNALBITS-1:0] max_o;
  logic                         valid_o;
  logic [WINBITS-1:0]           win_cnt_o;

  modport master (
    output log2_n, enable, clear, signal_i,
    input  signal_o, min_o, max_o, valid_o, win_cnt_o
  );

  modport slave (
    input  log2_n, enable, clear, signal_i,
    output signal_o, min_o, max_o, valid_o, win_cnt_o
  );
endinterface

// File: rtl/red_pitaya_decim_avg_block.sv
// Boxcar averager/decimator: floored mean, min and max over 2^n accepted samples.
module red_pitaya_decim_avg_block #(
  parameter int SIGNALBITS = 14,
  parameter int MAXLOG     = 10,
  parameter int LOGBITS    = 4,
  parameter int WINBITS    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  red_pitaya_decim_avg_block_if.slave   bus
);
  localparam int ACCW = SIGNALBITS + MAXLOG;
  localparam int NLW  = $clog2(MAXLOG + 1);
  localparam logic signed [SIGNALBITS-1:0] SMAX = {1'b0, {(SIGNALBITS-1){1'b1}}};
  localparam logic signed [SIGNALBITS-1:0] SMIN = {1'b1, {(SIGNALBITS-1){1'b0}}};

  logic signed [ACCW-1:0]       acc, sum, shifted;
  logic [MAXLOG-1:0]            cnt, cnt_last;
  logic [NLW-1:0]               n_lat, n_req;
  logic signed [SIGNALBITS-1:0] min_t, max_t, min_nx, max_nx;
  logic                         last;

  always_comb begin
    n_req = NLW'(bus.log2_n);
    if (int'(bus.log2_n) > MAXLOG) n_req = NLW'(MAXLOG);
  end

  // Terminal count 2^n_lat-1; a shift by the full width yields all ones.
  always_comb begin
    cnt_last = ~({MAXLOG{1'b1}} << n_lat);
    last     = (cnt == cnt_last);
    sum      = acc + {{MAXLOG{bus.signal_i[SIGNALBITS-1]}}, bus.signal_i};
    shifted  = sum >>> n_lat;
    min_nx   = (bus.signal_i < min_t) ? bus.signal_i : min_t;
    max_nx   = (bus.signal_i > max_t) ? bus.signal_i : max_t;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc           <= '0;
      cnt           <= '0;
      n_lat         <= n_req;
      min_t         <= SMAX;
      max_t         <= SMIN;
      bus.signal_o  <= '0;
      bus.min_o     <= '0;
      bus.max_o     <= '0;
      bus.valid_o   <= 1'b0;
      bus.win_cnt_o <= '0;
    end else begin
      bus.valid_o <= 1'b0;
      if (bus.clear) begin
        acc           <= '0;
        cnt           <= '0;
        n_lat         <= n_req;
        min_t         <= SMAX;
        max_t         <= SMIN;
        bus.win_cnt_o <= '0;
      end else if (bus.enable) begin
        if (last) begin
          // Mean of in-range samples is in range, so truncation is exact.
          bus.signal_o  <= shifted[SIGNALBITS-1:0];
          bus.min_o     <= min_nx;
          bus.max_o     <= max_nx;
          bus.valid_o   <= 1'b1;
          bus.win_cnt_o <= bus.win_cnt_o + 1'b1;
          acc           <= '0;
          cnt           <= '0;
          n_lat         <= n_req;
          min_t         <= SMAX;
          max_t         <= SMIN;
        end else begin
          acc   <= sum;
          cnt   <= cnt + 1'b1;
          min_t <= min_nx;
          max_t <= max_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_red_pitaya_decim_avg_block.sv
// Directed and randomized checks of the averager against a window-queue model.
module tb_red_pitaya_decim_avg_block;
  localparam int SB = 14, MAXLOG = 10, LB = 4, WB = 16;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  red_pitaya_decim_avg_block_if #(.SIGNALBITS(SB), .LOGBITS(LB), .WINBITS(WB)) bus ();

  red_pitaya_decim_avg_block #(.SIGNALBITS(SB), .MAXLOG(MAXLOG), .LOGBITS(LB), .WINBITS(WB)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );

  int ncmp = 0, nmis = 0;
  int win[$];
  int n_m = 0;
  int e_sig = 0, e_min = 0, e_max = 0, e_vld = 0, e_cnt = 0;
  int l2n = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampn(input int v);
    return (v > MAXLOG) ? MAXLOG : v;
  endfunction

  // Window model: collect samples, reduce when the window holds 2^n of them.
  task automatic model(input bit r, input bit c, input bit e, input int s);
    int len, sum, mn, mx, q;
    e_vld = 0;
    if (r) begin
      win.delete(); n_m = clampn(l2n);
      e_sig = 0; e_min = 0; e_max = 0; e_cnt = 0;
    end else if (c) begin
      win.delete(); n_m = clampn(l2n); e_cnt = 0;
    end else if (e) begin
      win.push_back(s);
      len = 1 << n_m;
      if (win.size() == len) begin
        sum = 0; mn = win[0]; mx = win[0];
        foreach (win[i]) begin
          sum += win[i];
          if (win[i] < mn) mn = win[i];
          if (win[i] > mx) mx = win[i];
        end
        q = sum / len;
        if (sum < 0 && (sum % len) != 0) q = q - 1;
        e_sig = q; e_min = mn; e_max = mx; e_vld = 1;
        e_cnt = (e_cnt + 1) % (1 << WB);
        win.delete(); n_m = clampn(l2n);
      end
    end
  endtask

  // Called at a negedge: drive, let the edge happen, check at the next negedge.
  task automatic step(input bit r, input bit c, input bit e, input int s, input string tag);
    logic [31:0] sv;
    sv = s;
    rst = r; bus.clear = c; bus.enable = e;
    bus.log2_n = LB'(l2n); bus.signal_i = sv[SB-1:0];
    @(posedge clk);
    model(r, c, e, s);
    @(negedge clk);
    chk({tag, ".sig"}, bus.signal_o, e_sig);
    chk({tag, ".min"}, bus.min_o, e_min);
    chk({tag, ".max"}, bus.max_o, e_max);
    chk({tag, ".vld"}, bus.valid_o, e_vld);
    chk({tag, ".cnt"}, bus.win_cnt_o, e_cnt);
  endtask

  int vals1[4] = '{10, 20, 30, 41};
  int v2[4] = '{-3, -4, -1, 0};
  int vcnt;

  initial begin
    rst = 1'b1; bus.clear = 1'b0; bus.enable = 1'b0; bus.log2_n = '0; bus.signal_i = '0;
    @(negedge clk);
    l2n = 2;
    step(1, 0, 0, 0, "reset");
    step(1, 0, 0, 0, "reset");
    chk("reset.sig0", bus.signal_o, 0);
    chk("reset.vld0", bus.valid_o, 0);

    // 1: basic mean/min/max
    for (int i = 0; i < 4; i++) step(0, 0, 1, vals1[i], "t1");
    chk("t1.mean", bus.signal_o, 25);
    chk("t1.min", bus.min_o, 10);
    chk("t1.max", bus.max_o, 41);
    chk("t1.valid", bus.valid_o, 1);
    chk("t1.wcnt", bus.win_cnt_o, 1);
    step(0, 0, 0, 0, "t1idle");
    chk("t1.pulse", bus.valid_o, 0);

    // 2: floor of negative means
    l2n = 1;
    step(0, 1, 0, 0, "t2clr");
    step(0, 0, 1, v2[0], "t2"); step(0, 0, 1, v2[1], "t2");
    chk("t2.floor_neg", bus.signal_o, -4);
    step(0, 0, 1, v2[2], "t2"); step(0, 0, 1, v2[3], "t2");
    chk("t2.floor_m1", bus.signal_o, -1);

    // 3: paused input every other cycle
    l2n = 3;
    step(0, 1, 0, 0, "t3clr");
    vcnt = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 0, (i % 2) == 0, 100, "t3");
      if (bus.valid_o) vcnt++;
    end
    chk("t3.vcount", vcnt, 1);
    chk("t3.valid_last", bus.valid_o, 1);
    chk("t3.mean", bus.signal_o, 100);

    // 4: clear aborts a partial window
    l2n = 2;
    step(0, 1, 0, 0, "t4clr");
    step(0, 0, 1, 50, "t4"); step(0, 0, 1, 60, "t4");
    step(0, 1, 1, 70, "t4clr3");
    for (int i = 0; i < 4; i++) step(0, 0, 1, 7, "t4");
    chk("t4.mean", bus.signal_o, 7);
    chk("t4.wcnt", bus.win_cnt_o, 1);

    // 5: clamped window at full scale
    l2n = 15;
    step(0, 1, 0, 0, "t5clr");
    for (int i = 0; i < 1024; i++) step(0, 0, 1, 8191, "t5p");
    chk("t5.pos", bus.signal_o, 8191);
    for (int i = 0; i < 1024; i++) step(0, 0, 1, -8192, "t5n");
    chk("t5.neg", bus.signal_o, -8192);
    chk("t5.wcnt", bus.win_cnt_o, 2);

    // 6: pass-through and mid-window reset
    l2n = 0;
    step(0, 1, 0, 0, "t6clr");
    for (int i = 0; i <= 5; i++) begin
      step(0, 0, 1, i, "t6");
      chk("t6.pass", bus.signal_o, i);
    end
    l2n = 2;
    step(0, 1, 0, 0, "t6clr2");
    step(0, 0, 1, 33, "t6w"); step(0, 0, 1, 44, "t6w");
    step(1, 0, 0, 0, "t6rst");
    chk("t6.rst_sig", bus.signal_o, 0);
    chk("t6.rst_cnt", bus.win_cnt_o, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 12, "t6fresh");
    chk("t6.fresh", bus.signal_o, 12);

    // Random mix of window sizes, pauses, clears and resets
    for (int i = 0; i < 3000; i++) begin
      bit r, c, e;
      int s;
      if ($urandom_range(0, 49) == 0) l2n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 99) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = int'($urandom_range(0, 16383)) - 8192;
      step(r, c, e, s, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
